multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle control unit for the ARM-subset processor. Sequences fetch, decode, memory, ALU and branch steps over 3-5 cycles.
//  Drives the sign-extender op select (ImmSrc), the datapath muxes and all architectural write enables.
//  Holds the NZCV flag register and evaluates the 4-bit condition field of every instruction.
// PARAMETERS
//  none (all encodings live in ctrl_pkg)
// PORTS
//  clk         in   1   single system clock, rising edge
//  reset       in   1   synchronous, active-high
//  Cond        in   4   Instr[31:28] condition field (from IR)
//  Op          in   2   Instr[27:26]: 00 data-proc, 01 memory, 10 branch
//  Funct       in   6   Instr[25:20]: I, cmd[3:0], S/L bit
//  Rd          in   4   Instr[15:12] destination register
//  ALUFlags    in   4   NZCV from ALU, current cycle
//  PCWrite     out  1   PC register enable
//  MemWrite    out  1   data memory write enable
//  RegWrite    out  1   register file write enable
//  IRWrite     out  1   instruction register enable
//  AdrSrc      out  1   memory address: 0=PC, 1=ALUOut/Result
//  RegSrc      out  2   [0]=1 read R15 as RA1; [1]=1 read Rd as RA2 (STR)
//  ALUSrcA     out  1   0=RD1, 1=PC
//  ALUSrcB     out  2   00=RD2, 01=ExtImm, 10=constant 4
//  ResultSrc   out  2   00=ALUOut, 01=Data, 10=ALUResult
//  ImmSrc      out  2   to sign-extender: 00 DP imm12, 01 mem offset12, 10 branch imm24
//  ALUControl  out  2   00 ADD, 01 SUB, 10 AND, 11 ORR
// BEHAVIOUR
//  - Reset (sync): state<=FETCH, Flags<=4'b0000; while reset=1 all write enables (PCWrite, MemWrite, RegWrite, IRWrite) forced 0.
//  - Outputs are combinational from registered state + current Op/Funct/Cond; non-enable outputs default 0 in unused states.
//  - States and transitions (one per cycle, no stalls):
//    FETCH:    IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 -> DECODE
//    DECODE:   ALUSrcA=1, ALUSrcB=10, ResultSrc=10, RegSrc[0]=(Op==10), RegSrc[1]=(Op==01)
//              Op=01 -> MEMADR; Op=00 & Funct[5] -> EXECUTEI; Op=00 -> EXECUTER; Op=10 -> BRANCH; Op=11 -> FETCH (no writes)
//    MEMADR:   ALUSrcA=0, ALUSrcB=01, ADD, ImmSrc=01 -> Funct[0] ? MEMRD : MEMWR
//    MEMRD:    AdrSrc=1 -> MEMWB
//    MEMWB:    ResultSrc=01, RegWrite=CondEx -> FETCH
//    MEMWR:    AdrSrc=1, MemWrite=CondEx -> FETCH
//    EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUControl from cmd -> ALUWB
//    EXECUTEI: ALUSrcA=0, ALUSrcB=01, ImmSrc=00, ALUControl from cmd -> ALUWB
//    ALUWB:    ResultSrc=00, RegWrite=CondEx & !CMP; if Rd==15 also PCWrite=CondEx -> FETCH
//    BRANCH:   ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ADD, ResultSrc=10, PCWrite=CondEx -> FETCH
//  - cmd decode: 0100 ADD, 0010 SUB, 1010 CMP (SUB, no reg write), 0000 AND, 1100 ORR; any other cmd -> ADD, RegWrite=0.
//  - Flags: written with ALUFlags at end of EXECUTER/EXECUTEI iff Funct[0]=1 and CondEx; CMP always treated as S=1.
//  - CondEx from registered Flags: EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE per ARM; 1110 AL=1; 1111 =0 (never).
//  - Failed condition: sequence still runs all states; only enables and flag write suppressed. Latency unchanged.
//  - Latency: LDR 5, STR 4, DP 4, B 3 cycles. Reset mid-instruction aborts it; next cycle is FETCH, no partial write.
// STRUCTURE
//  - ctrl_pkg: state_t enum (FETCH..BRANCH), ImmSrc/ALUSrcB/ResultSrc/ALUControl localparams, cond code constants.
//  - Sub-module cond_unit: Flags register + CondEx evaluation; instantiated once, gated write enable from FSM.
// TESTING
//  - Reset held 2 cycles mid-MEMWR -> MemWrite=0 throughout, state FETCH, Flags=0000 after release.
//  - LDR (Op=01, Funct=011001, Cond=1110) -> 5 cycles, ImmSrc=01 in MEMADR, RegWrite=1 only in MEMWB.
//  - CMP imm (Funct=110101) ALUFlags=0100 -> RegWrite=0, Flags=0100; following BEQ (Cond=0000, Op=10) -> PCWrite=1 in BRANCH, ImmSrc=10.
//  - BNE (Cond=0001) with Z=1 -> 3 cycles, PCWrite high only in FETCH, never in BRANCH.
//  - ADD reg to Rd=15, Cond=1110 -> ALUWB asserts RegWrite=1 and PCWrite=1; Cond=1111 same instr -> both 0.
//  - Op=11 undefined -> FETCH, DECODE, FETCH; no write enables except FETCH PCWrite/IRWrite.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit:
// FSM states, datapath mux selects, ALU ops, cmd and condition codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH
  } state_t;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] SRCB_RD2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register and condition-field evaluation.
// CondEx always reflects the currently registered flags.
module cond_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic       i_flag_we,
  output logic       o_cond_ex
);

  logic [3:0] r_flags;
  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (i_flag_we) begin
      r_flags <= i_alu_flags;
    end
  end

  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    o_cond_ex = 1'b0;
    case (i_cond)
      COND_EQ: o_cond_ex = w_z;
      COND_NE: o_cond_ex = ~w_z;
      COND_CS: o_cond_ex = w_c;
      COND_CC: o_cond_ex = ~w_c;
      COND_MI: o_cond_ex = w_n;
      COND_PL: o_cond_ex = ~w_n;
      COND_VS: o_cond_ex = w_v;
      COND_VC: o_cond_ex = ~w_v;
      COND_HI: o_cond_ex = w_c & ~w_z;
      COND_LS: o_cond_ex = ~w_c | w_z;
      COND_GE: o_cond_ex = (w_n == w_v);
      COND_LT: o_cond_ex = (w_n != w_v);
      COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
      COND_LE: o_cond_ex = w_z | (w_n != w_v);
      COND_AL: o_cond_ex = 1'b1;
      default: o_cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the ARM-subset core: sequences
// fetch/decode/mem/alu/branch steps and gates all write enables.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] RegSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUControl
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_cmd;
  logic [1:0] w_alu_op;
  logic       w_cmd_ok;
  logic       w_is_cmp;
  logic       w_cond_ex;
  logic       w_flag_we;

  assign w_cmd = Funct[4:1];

  // Unknown cmds still run as ADD but never write back.
  always_comb begin
    w_alu_op = ALU_ADD;
    w_cmd_ok = 1'b1;
    w_is_cmp = 1'b0;
    unique case (1'b1)
      (w_cmd == CMD_ADD): w_alu_op = ALU_ADD;
      (w_cmd == CMD_SUB): w_alu_op = ALU_SUB;
      (w_cmd == CMD_CMP): begin
        w_alu_op = ALU_SUB;
        w_is_cmp = 1'b1;
      end
      (w_cmd == CMD_AND): w_alu_op = ALU_AND;
      (w_cmd == CMD_ORR): w_alu_op = ALU_ORR;
      default: w_cmd_ok = 1'b0;
    endcase
  end

  assign w_flag_we = ((r_state == EXECUTER) ||
                      (r_state == EXECUTEI)) &&
                     (Funct[0] || w_is_cmp) && w_cond_ex;

  cond_unit u_cond (
    .clk         (clk),
    .reset       (reset),
    .i_cond      (Cond),
    .i_alu_flags (ALUFlags),
    .i_flag_we   (w_flag_we),
    .o_cond_ex   (w_cond_ex)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = FETCH;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    RegSrc     = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RD2;
    ResultSrc  = RES_ALUOUT;
    ImmSrc     = IMM_DP;
    ALUControl = ALU_ADD;
    unique case (r_state)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALU;
        PCWrite   = 1'b1;
        w_next    = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALU;
        RegSrc    = {Op == OP_MEM, Op == OP_BR};
        unique case (Op)
          OP_MEM:  w_next = MEMADR;
          OP_DP:   w_next = Funct[5] ? EXECUTEI
                                     : EXECUTER;
          OP_BR:   w_next = BRANCH;
          default: w_next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_MEM;
        w_next  = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        w_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = w_cond_ex;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = w_cond_ex;
      end
      EXECUTER: begin
        ALUControl = w_alu_op;
        w_next     = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = w_alu_op;
        w_next     = ALUWB;
      end
      ALUWB: begin
        RegWrite = w_cond_ex & w_cmd_ok & ~w_is_cmp;
        PCWrite  = w_cond_ex & (Rd == 4'd15);
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ImmSrc    = IMM_BR;
        ResultSrc = RES_ALU;
        PCWrite   = w_cond_ex;
      end
      default: w_next = FETCH;
    endcase
    // Reset must never leak a partial architectural write.
    if (reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      IRWrite  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Random + directed instruction-level bench for multicycle_ctrl.
// Expected per-cycle outputs are derived per instruction class.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] Cond = 4'h0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'h00;
  logic [3:0] Rd = 4'h0;
  logic [3:0] ALUFlags = 4'h0;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

  int nvec = 0;
  int nerr = 0;
  logic [3:0] flags = 4'h0;
  logic [7:0] tr_pcw, tr_rw, tr_mw;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct),
    .Rd(Rd), .ALUFlags(ALUFlags), .PCWrite(PCWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl)
  );

  always #5 clk = ~clk;

  wire [15:0] dut_v = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
                       RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
                       ALUControl};

  function automatic logic [15:0] v(
    input logic pcw, mw, rw, irw, adr, input logic [1:0] rs,
    input logic sa, input logic [1:0] sb, res, imm, alu);
    return {pcw, mw, rw, irw, adr, rs, sa, sb, res, imm, alu};
  endfunction

  function automatic logic cond_ok(input logic [3:0] c,
                                   input logic [3:0] f);
    logic n, z, cy, ov;
    {n, z, cy, ov} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return ov;
      4'h7: return !ov;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == ov;
      4'hB: return n != ov;
      4'hC: return !z && (n == ov);
      4'hD: return z || (n != ov);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Runs one instruction from FETCH; rst_at>=0 asserts reset for
  // two cycles starting at that cycle index, aborting the instruction.
  task automatic instr(input logic [1:0] op, input logic [5:0] fn,
                       input logic [3:0] cnd, input logic [3:0] rd,
                       input logic [3:0] af, input int rst_at_in);
    logic [15:0] q[$];
    logic [15:0] exp;
    logic [15:0] fetch_v;
    logic [3:0]  f;
    logic [3:0]  cmd;
    logic [1:0]  alu;
    logic        ce, ce2, cmp, ok;
    int          n, rst_at;
    f = flags;
    fetch_v = v(1, 0, 0, 1, 0, 2'b00, 1, 2'b10, 2'b10, 2'b00, 2'b00);
    q.push_back(fetch_v);
    q.push_back(v(0, 0, 0, 0, 0, {op == 2'b01, op == 2'b10}, 1,
                  2'b10, 2'b10, 2'b00, 2'b00));
    ce = cond_ok(cnd, f);
    case (op)
      2'b01: begin
        q.push_back(v(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b01, 0));
        if (fn[0]) begin
          q.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
          q.push_back(v(0, 0, ce, 0, 0, 0, 0, 0, 2'b01, 0, 0));
        end else begin
          q.push_back(v(0, ce, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        end
      end
      2'b00: begin
        cmd = fn[4:1];
        ok = 1'b1;
        cmp = 1'b0;
        alu = 2'b00;
        case (cmd)
          4'b0100: alu = 2'b00;
          4'b0010: alu = 2'b01;
          4'b1010: begin alu = 2'b01; cmp = 1'b1; end
          4'b0000: alu = 2'b10;
          4'b1100: alu = 2'b11;
          default: ok = 1'b0;
        endcase
        q.push_back(v(0, 0, 0, 0, 0, 0, 0, fn[5] ? 2'b01 : 2'b00,
                      0, 0, alu));
        if ((fn[0] || cmp) && ce) f = af;
        ce2 = cond_ok(cnd, f);
        q.push_back(v(ce2 && (rd == 4'd15), 0, ce2 && ok && !cmp,
                      0, 0, 0, 0, 0, 0, 0, 0));
      end
      2'b10: q.push_back(v(ce, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10,
                           2'b10, 0));
      default: ;
    endcase
    rst_at = rst_at_in;
    if (rst_at >= q.size()) rst_at = q.size() - 1;
    n = (rst_at >= 0) ? rst_at + 2 : q.size();
    tr_pcw = '0;
    tr_rw = '0;
    tr_mw = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      Op = op;
      Funct = fn;
      Cond = cnd;
      Rd = rd;
      ALUFlags = (op == 2'b00 && i == 2) ? af : 4'($urandom);
      reset = (rst_at >= 0 && i >= rst_at);
      if (rst_at >= 0 && i > rst_at) exp = fetch_v & 16'h0FFF;
      else if (rst_at >= 0 && i == rst_at) exp = q[i] & 16'h0FFF;
      else exp = q[i];
      #1;
      chk($sformatf("op%0d cyc%0d", op, i), dut_v, exp);
      tr_pcw[i] = PCWrite;
      tr_rw[i] = RegWrite;
      tr_mw[i] = MemWrite;
    end
    flags = (rst_at >= 0) ? 4'h0 : f;
  endtask

  initial begin
    int ra;
    logic [3:0] cmds[5];
    logic [5:0] fn;
    logic [3:0] cmd;
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b1010;
    cmds[3] = 4'b0000; cmds[4] = 4'b1100;

    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("reset enables", {12'h0, PCWrite, MemWrite, RegWrite, IRWrite},
          16'h0);
    end

    instr(2'b01, 6'b011001, 4'hE, 4'd3, 4'h0, -1);
    chk("LDR regwrite trace", {8'h0, tr_rw}, 16'h0010);

    instr(2'b00, 6'b110101, 4'hE, 4'd0, 4'b0100, -1);
    chk("CMP regwrite trace", {8'h0, tr_rw}, 16'h0000);
    instr(2'b10, 6'b100000, 4'h0, 4'd0, 4'h0, -1);
    chk("BEQ taken pcwrite", {8'h0, tr_pcw}, 16'h0005);
    instr(2'b10, 6'b100000, 4'h1, 4'd0, 4'h0, -1);
    chk("BNE Z=1 pcwrite", {8'h0, tr_pcw}, 16'h0001);

    instr(2'b01, 6'b011000, 4'hE, 4'd2, 4'h0, 3);
    chk("reset mid-STR memwrite", {8'h0, tr_mw}, 16'h0000);
    instr(2'b10, 6'b100000, 4'h1, 4'd0, 4'h0, -1);
    chk("BNE after reset", {8'h0, tr_pcw}, 16'h0005);

    instr(2'b00, 6'b001000, 4'hE, 4'd15, 4'h0, -1);
    chk("ADD pc AL regwrite", {8'h0, tr_rw}, 16'h0008);
    chk("ADD pc AL pcwrite", {8'h0, tr_pcw}, 16'h0009);
    instr(2'b00, 6'b001000, 4'hF, 4'd15, 4'h0, -1);
    chk("ADD pc NV regwrite", {8'h0, tr_rw}, 16'h0000);
    chk("ADD pc NV pcwrite", {8'h0, tr_pcw}, 16'h0001);

    instr(2'b11, 6'b000000, 4'hE, 4'd0, 4'h0, -1);
    chk("undef op pcwrite", {8'h0, tr_pcw}, 16'h0001);

    for (int k = 0; k < 400; k++) begin
      cmd = ($urandom_range(0, 3) != 0) ? cmds[$urandom_range(0, 4)]
                                       : 4'($urandom);
      fn = {1'($urandom), cmd, 1'($urandom)};
      ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
      instr(2'($urandom), fn,
            ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom),
            ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom),
            4'($urandom), ra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
